// File: rtl/zad4_pkg.sv
// Shared definitions for the zad4 registered adder: default width and the
// packed flag bundle passed from the combinational core to the output register.
package zad4_pkg;

  localparam int ZAD4_DEF_WIDTH = 4;

  typedef struct packed {
    logic carry;  // carry-out of the unsigned sum
    logic ovf;    // two's-complement overflow of the wrapped sum
    logic zero;   // final result is all zeros
  } zad4_flags_t;

endpackage : zad4_pkg

// File: rtl/zad4_add_core.sv
// Combinational heart of zad4_adder: full-width sum, optional saturation and
// flag generation. Saturation is enabled by defining ZAD4_SATURATE_EN.
module zad4_add_core
  import zad4_pkg::*;
#(
  parameter int WIDTH = ZAD4_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output zad4_flags_t      flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] o_wrapped;

  // Sum, optional clamp and flags; overflow always looks at the wrapped sum.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o           = '0;
    flags       = '0;
    sum         = {1'b0, a} + {1'b0, b};
    o_wrapped   = sum[WIDTH-1:0];
    flags.carry = sum[WIDTH];
    flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (o_wrapped[WIDTH-1] != a[WIDTH-1]);
`ifdef ZAD4_SATURATE_EN
    o = flags.carry ? {WIDTH{1'b1}} : o_wrapped;
`else
    o = o_wrapped;
`endif
    flags.zero = (o == '0);
  end

endmodule : zad4_add_core

// File: rtl/zad4_adder.sv
// Registered unsigned adder with carry/overflow/zero flags and a one-cycle
// valid pipeline. Define ZAD4_SATURATE_EN to clamp the result on carry-out.
module zad4_adder
  import zad4_pkg::*;
#(
  parameter int WIDTH = ZAD4_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] o_next;
  zad4_flags_t      flags_next;
  zad4_flags_t      flags_q;

  zad4_add_core #(.WIDTH(WIDTH)) u_core (
    .a     (a),
    .b     (b),
    .o     (o_next),
    .flags (flags_next)
  );

  // Capture result and flags on each accepted pair; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      o       <= '0;
      flags_q <= '{carry: 1'b0, ovf: 1'b0, zero: 1'b1};
    end else if (in_valid) begin
      o       <= o_next;
      flags_q <= flags_next;
    end
  end

  // Single-cycle valid strobe following every accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  assign carry = flags_q.carry;
  assign ovf   = flags_q.ovf;
  assign zero  = flags_q.zero;

endmodule : zad4_adder

// File: tb/tb_zad4_adder.sv
// Self-checking bench for zad4_adder: directed vector table, hold and reset
// sequences, then random traffic against an arithmetic reference model.
module tb_zad4_adder;

  localparam int W = 4;
`ifdef ZAD4_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] o;
  logic         carry, ovf, zero, out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int a;
    int b;
    int o;
    int c;
    int v;
    int z;
  } vec_t;

  vec_t vecs[7];

  // reference state (what the registered outputs should show)
  int exp_o = 0, exp_c = 0, exp_v = 0, exp_z = 1;

  zad4_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .o         (o),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int eo, input int ec,
                           input int ev, input int ez, input int evalid);
    check({tag, ".o"},         int'(o),         eo);
    check({tag, ".carry"},     int'(carry),     ec);
    check({tag, ".ovf"},       int'(ovf),       ev);
    check({tag, ".zero"},      int'(zero),      ez);
    check({tag, ".out_valid"}, int'(out_valid), evalid);
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int ia, input int ib,
                       output int ro, output int rc, output int rv, output int rz);
    int full, sa, sb, ssum;
    full = ia + ib;
    rc   = (full >= (1 << W)) ? 1 : 0;
    ro   = (SAT && rc == 1) ? (1 << W) - 1 : full % (1 << W);
    sa   = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
    sb   = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
    ssum = sa + sb;
    rv   = (ssum > (1 << (W - 1)) - 1 || ssum < -(1 << (W - 1))) ? 1 : 0;
    rz   = (ro == 0) ? 1 : 0;
  endtask

  // Drive one cycle's inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input int ia, input int ib, input bit v);
    @(negedge clk);
    a        = W'(ia);
    b        = W'(ib);
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{a: 0,  b: 3,  o: 3,             c: 0, v: 0, z: 0};
    vecs[1] = '{a: 3,  b: 3,  o: 6,             c: 0, v: 0, z: 0};
    vecs[2] = '{a: 1,  b: 1,  o: 2,             c: 0, v: 0, z: 0};
    vecs[3] = '{a: 15, b: 3,  o: SAT ? 15 : 2,  c: 1, v: 0, z: 0};
    vecs[4] = '{a: 15, b: 15, o: SAT ? 15 : 14, c: 1, v: 0, z: 0};
    vecs[5] = '{a: 7,  b: 1,  o: 8,             c: 0, v: 1, z: 0};
    vecs[6] = '{a: 8,  b: 8,  o: SAT ? 15 : 0,  c: 1, v: 1, z: SAT ? 0 : 1};

    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check_all("reset", 0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back directed vectors
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, 1'b1);
      check_all($sformatf("vec%0d", i), vecs[i].o, vecs[i].c, vecs[i].v, vecs[i].z, 1);
    end

    // hold: 3+3 then drop in_valid with changing operands
    step(3, 3, 1'b1);
    check_all("hold_load", 6, 0, 0, 0, 1);
    step(15, 15, 1'b0);
    check_all("hold1", 6, 0, 0, 0, 0);
    step(9, 12, 1'b0);
    check_all("hold2", 6, 0, 0, 0, 0);

    // mid-operation reset pulse between edges, then recovery
    step(5, 6, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 check_all("midrst", 0, 0, 0, 1, 0);
    #1 rst = 1'b0;
    step(1, 1, 1'b1);
    check_all("post_rst", 2, 0, 0, 0, 1);
    exp_o = 2; exp_c = 0; exp_v = 0; exp_z = 0;

    // random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      int ra, rb, ro, rc, rv, rz;
      bit rvld;
      ra   = $urandom_range(0, (1 << W) - 1);
      rb   = $urandom_range(0, (1 << W) - 1);
      rvld = ($urandom_range(0, 3) != 0);
      step(ra, rb, rvld);
      if (rvld) begin
        model(ra, rb, ro, rc, rv, rz);
        exp_o = ro; exp_c = rc; exp_v = rv; exp_z = rz;
      end
      check_all($sformatf("rnd%0d", i), exp_o, exp_c, exp_v, exp_z, int'(rvld));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_zad4_adder
